ntt_sched: RTL
==============

Name: ntt_sched

Overview:
- Sequencer for one radix-2 butterfly unit of the NTT kernel.
- On start, walks all log2(N) stages and issues (addr_a, addr_b, twiddle index, mode) per butterfly over a valid/ready handshake, one op per cycle.
- Counts butterfly completions and holds a barrier between stages, so stage s+1 never reads data that stage s has not written back.
- Supports forward NTT (Cooley-Tukey ordering) and inverse NTT (Gentleman-Sande ordering).

Parameters:
- pLOG_N, 8, log2 of transform size N; legal range 2..15.
- pMAX_OUT, 8, maximum butterflies issued but not yet completed; legal range 1..255.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, asynchronous, active-low.
- start  input  1  begin a transform; sampled only in IDLE.
- mode_i  input  1  0 = forward NTT, 1 = inverse NTT; captured with start.
- busy  output  1  high from start acceptance until the final drain completes.
- done  output  1  one-cycle pulse at transform completion.
- err  output  1  sticky: cmp_vld received while outstanding == 0; cleared on accepted start.
- iss_vld  output  1  butterfly op valid.
- iss_rdy  input  1  butterfly accepts op.
- iss_mode  output  1  captured mode, forwarded to the butterfly.
- iss_addr_a  output  pLOG_N  upper-leg coefficient index.
- iss_addr_b  output  pLOG_N  lower-leg coefficient index.
- iss_tw  output  pLOG_N  twiddle ROM index (range 1..N-1).
- iss_stage  output  4  current stage, 0..pLOG_N-1.
- iss_last  output  1  marks the final op of the final stage.
- cmp_vld  input  1  one butterfly write-back completed this cycle.

Behaviour:
- Reset: state IDLE; all outputs 0; stage, group and index counters 0; outstanding 0; captured mode 0. Reset mid-transform aborts immediately; no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE -> ISSUE: on start=1. Captures mode_i, clears err, loads stage 0 / op 0. iss_vld and busy go high on the next cycle.
  - ISSUE: iss_vld held high and payload held stable until iss_vld&iss_rdy. The next op is presented the following cycle, giving 1 op/cycle at full throughput.
  - ISSUE -> DRAIN: after the last op of a stage is accepted. iss_vld goes 0 next cycle.
  - DRAIN -> ISSUE: on the edge where next-outstanding == 0 and stages remain. The first op of stage+1 is valid the next cycle.
  - DRAIN -> DONE: when next-outstanding == 0 after the final stage.
  - DONE -> IDLE: unconditional after one cycle. done=1 and busy=0 in DONE.
- Stall: iss_vld is forced 0 in ISSUE while outstanding == pMAX_OUT. A completion in the same cycle does not release the stall until the next cycle. The payload is held across the stall.
- Outstanding counter:
  - +1 on issue handshake; -1 on cmp_vld; unchanged when both occur.
  - cmp_vld at 0: counter saturates at 0 and err is set.
- start while busy or in DONE is ignored.
- Op order per stage s is group g outer, k inner, with half h and G groups per stage:
  - Forward: h = N>>(s+1), G = 1<<s, iss_tw = (1<<s) + g.
  - Inverse: h = 1<<s, G = N>>(s+1), iss_tw = (N>>s) - 1 - g.
  - Both: iss_addr_a = g*2h + k, iss_addr_b = iss_addr_a + h, k = 0..h-1.
- Each stage has N/2 ops; a transform has pLOG_N stages.
- Widths: address arithmetic is pLOG_N bits, implemented as shifts and masks (no multipliers); no wrap occurs within legal ranges.
- iss_last = 1 only with the op where s = pLOG_N-1, g = G-1, k = h-1.

Test Plan:
- pLOG_N=3, forward, iss_rdy=1, completions returned 2 cycles after issue -> exact sequence required:
  - Stage 0: (0,4,1) (1,5,1) (2,6,1) (3,7,1).
  - Stage 1: (0,2,2) (1,3,2) (4,6,3) (5,7,3).
  - Stage 2: (0,1,4) (2,3,5) (4,5,6) (6,7,7).
  - iss_last on (6,7,7); done pulses once; iss_mode=0 throughout.
- pLOG_N=3, inverse -> exact sequence required:
  - Stage 0: (0,1,7) (2,3,6) (4,5,5) (6,7,4).
  - Stage 1: (0,2,3) (1,3,3) (4,6,2) (5,7,2).
  - Stage 2: (0,4,1) (1,5,1) (2,6,1) (3,7,1).
  - iss_mode=1 throughout.
- Stage barrier: pMAX_OUT=8, hold cmp_vld off for 10 cycles after stage 0 -> iss_vld stays 0 during DRAIN; stage 1's first op appears exactly 1 cycle after the 4th completion.
- Backpressure and credit: pMAX_OUT=2, random iss_rdy -> payload stable while vld&!rdy; never more than 2 outstanding; full sequence unchanged; no op skipped or duplicated.
- Errors and races:
  - Spurious cmp_vld in IDLE -> err=1 and outstanding stays 0; next start clears err.
  - start pulsed mid-transform -> ignored.
- Reset mid-transform: assert rstn=0 during stage 1 -> all outputs 0 asynchronously; no done pulse; a fresh start restarts at stage 0 op (0,4,1).

Source files
------------

// File: rtl/ntt_sched.sv
// rtl/ntt_sched.sv - radix-2 NTT butterfly op sequencer with stage barrier and credit limit
module ntt_sched #(
  parameter int pLOG_N   = 8,
  parameter int pMAX_OUT = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              mode_i,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              iss_vld,
  input  logic              iss_rdy,
  output logic              iss_mode,
  output logic [pLOG_N-1:0] iss_addr_a,
  output logic [pLOG_N-1:0] iss_addr_b,
  output logic [pLOG_N-1:0] iss_tw,
  output logic [3:0]        iss_stage,
  output logic              iss_last,
  input  logic              cmp_vld
);

  localparam logic [7:0]        MAX_OUT    = 8'(pMAX_OUT);
  localparam logic [3:0]        LAST_STAGE = 4'(pLOG_N - 1);
  localparam logic [3:0]        LOG_N      = 4'(pLOG_N);
  localparam logic [pLOG_N-1:0] ONE_N      = {{(pLOG_N-1){1'b0}}, 1'b1};
  localparam logic [pLOG_N-1:0] ONES_N     = {pLOG_N{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [3:0]        stage_q, stage_d;
  logic [pLOG_N-1:0] grp_q, grp_d;
  logic [pLOG_N-1:0] idx_q, idx_d;
  logic [7:0]        out_q, out_d;
  logic              mode_q, mode_d;
  logic              err_q, err_d;

  // Per-stage geometry: lh = log2(half span), lg = log2(group count)
  logic [3:0]        lh, lg;
  logic [pLOG_N-1:0] half, idx_max, grp_max;
  logic [pLOG_N-1:0] addr_a, addr_b, tw;
  logic              in_issue, vld, hs, idx_end, grp_end;

  // Derive butterfly addressing from the stage/group/index counters
  always_comb begin
    lh      = mode_q ? stage_q : (LAST_STAGE - stage_q);
    lg      = LAST_STAGE - lh;
    half    = ONE_N << lh;
    idx_max = ~(ONES_N << lh);
    grp_max = ~(ONES_N << lg);
    // Group base g*2h is a shift because 2h is a power of two; bit lh of addr_a is always clear
    addr_a  = (grp_q << (lh + 4'd1)) | idx_q;
    addr_b  = addr_a | half;
    // Forward: (1<<s)+g; inverse: (N>>s)-1-g, where (N>>s)-1 is an all-ones mask
    tw      = mode_q ? ((ONES_N >> stage_q) - grp_q) : ((ONE_N << stage_q) + grp_q);
    idx_end = (idx_q == idx_max);
    grp_end = (grp_q == grp_max);
  end

  assign in_issue = (state_q == S_ISSUE);
  assign vld      = in_issue && (out_q != MAX_OUT);
  assign hs       = vld && iss_rdy;

  // Outstanding counter and sticky error on a completion with nothing in flight
  always_comb begin
    out_d = out_q;
    err_d = err_q;
    case ({hs, cmp_vld})
      2'b10:   out_d = out_q + 8'd1;
      2'b01:   out_d = (out_q == 8'd0) ? 8'd0 : (out_q - 8'd1);
      default: out_d = out_q;
    endcase
    if (state_q == S_IDLE && start) err_d = 1'b0;
    if (cmp_vld && out_q == 8'd0)   err_d = 1'b1;
  end

  // Next-state logic: issue a stage, drain it to zero outstanding, then advance
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    grp_d   = grp_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          mode_d  = mode_i;
          stage_d = 4'd0;
          grp_d   = '0;
          idx_d   = '0;
        end
      end
      S_ISSUE: begin
        if (hs) begin
          if (idx_end) begin
            idx_d = '0;
            if (grp_end) begin
              grp_d   = '0;
              state_d = S_DRAIN;
            end else begin
              grp_d = grp_q + ONE_N;
            end
          end else begin
            idx_d = idx_q + ONE_N;
          end
        end
      end
      S_DRAIN: begin
        if (out_d == 8'd0) begin
          if (stage_q == LAST_STAGE) begin
            state_d = S_DONE;
          end else begin
            stage_d = stage_q + 4'd1;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      stage_q <= 4'd0;
      grp_q   <= '0;
      idx_q   <= '0;
      out_q   <= 8'd0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      grp_q   <= grp_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  // Payload is held through stalls and zeroed outside ISSUE
  always_comb begin
    busy       = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    done       = (state_q == S_DONE);
    err        = err_q;
    iss_vld    = vld;
    iss_mode   = mode_q;
    iss_addr_a = in_issue ? addr_a  : '0;
    iss_addr_b = in_issue ? addr_b  : '0;
    iss_tw     = in_issue ? tw      : '0;
    iss_stage  = in_issue ? stage_q : 4'd0;
    iss_last   = in_issue && idx_end && grp_end && (stage_q == LAST_STAGE);
  end

endmodule
